// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer_alarm block: register map, bit positions
// and the 64-bit time type.
package timer_alarm_pkg;

    // Word addresses of the Avalon-visible registers
    typedef enum logic [2:0] {
        REG_CONTROL = 3'd0,
        REG_STATUS  = 3'd1,
        REG_CMP_LO  = 3'd2,
        REG_CMP_HI  = 3'd3,
        REG_PER_LO  = 3'd4,
        REG_PER_HI  = 3'd5,
        REG_SNAP_LO = 3'd6,
        REG_SNAP_HI = 3'd7
    } reg_addr_e;

    // CONTROL bit positions
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_W        = 3;

    // STATUS bit positions
    localparam int unsigned STAT_PEND   = 0;
    localparam int unsigned STAT_MISSED = 1;

    // Timestamp / compare / period values
    typedef logic [63:0] ts_t;

endpackage

// File: rtl/timer_alarm_cmp.sv
// Combinational deadline comparator: decides whether the alarm fires this
// cycle and, for periodic alarms, what the next deadline should be.
module timer_alarm_cmp
    import timer_alarm_pkg::*;
(
    input  ts_t  timestamp,
    input  ts_t  compare,
    input  ts_t  period,
    input  logic periodic,
    output logic hit,
    output ts_t  next,
    output logic overrun,
    output logic reload
);

    ts_t advanced;

    // Fire on reach-or-pass; a zero period degrades to one-shot so the
    // deadline can never stall on the current timestamp.
    always_comb begin
        advanced = compare + period;
        hit      = (timestamp >= compare);
        reload   = hit && periodic && (period != '0);
        overrun  = reload && !(advanced > timestamp);
        next     = overrun ? (timestamp + period) : advanced;
    end

endmodule

// File: rtl/timer_alarm.sv
// Avalon-MM timestamp alarm: programmable 64-bit deadline with one-shot and
// periodic modes, overrun detection, level irq and a tear-free snapshot.
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int TS_W   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TS_W-1:0]   timestamp,
    input  logic [ADDR_W-1:0] avalon_slave_address,
    input  logic              avalon_slave_read,
    output logic [31:0]       avalon_slave_readdata,
    input  logic              avalon_slave_write,
    input  logic [31:0]       avalon_slave_writedata,
    output logic              irq
);

    logic [CTRL_W-1:0] ctrl;
    logic              pend;
    logic              missed;
    ts_t               compare;
    ts_t               period;
    logic [31:0]       cmp_shadow;
    logic [31:0]       per_shadow;
    logic [31:0]       snap_hi;
    reg_addr_e         addr;
    logic              wr_en;
    logic              fire;
    logic              hit;
    logic              overrun;
    logic              reload;
    ts_t               next;
    logic [31:0]       rd_mux;

    assign addr  = reg_addr_e'(avalon_slave_address);
    assign wr_en = avalon_slave_write;
    assign fire  = ctrl[CTRL_EN] && hit;

    timer_alarm_cmp u_cmp (
        .timestamp (timestamp),
        .compare   (compare),
        .period    (period),
        .periodic  (ctrl[CTRL_PERIODIC]),
        .hit       (hit),
        .next      (next),
        .overrun   (overrun),
        .reload    (reload)
    );

    // Control, compare and period: hardware update first, software write
    // afterwards so a same-cycle bus write overrides the alarm's update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl       <= '0;
            compare    <= '0;
            period     <= '0;
            cmp_shadow <= '0;
            per_shadow <= '0;
        end else begin
            if (fire) begin
                if (reload) begin
                    compare <= next;
                end else begin
                    ctrl[CTRL_EN] <= 1'b0;
                end
            end
            if (wr_en) begin
                case (addr)
                    REG_CONTROL: ctrl       <= avalon_slave_writedata[CTRL_W-1:0];
                    REG_CMP_LO:  cmp_shadow <= avalon_slave_writedata;
                    REG_CMP_HI:  compare    <= {avalon_slave_writedata, cmp_shadow};
                    REG_PER_LO:  per_shadow <= avalon_slave_writedata;
                    REG_PER_HI:  period     <= {avalon_slave_writedata, per_shadow};
                    default: ;
                endcase
            end
        end
    end

    // Status flags: software W1C first, hardware set last so the set wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend   <= 1'b0;
            missed <= 1'b0;
        end else begin
            if (wr_en && (addr == REG_STATUS)) begin
                if (avalon_slave_writedata[STAT_PEND]) pend <= 1'b0;
                if (avalon_slave_writedata[STAT_MISSED]) missed <= 1'b0;
            end
            if (fire) pend <= 1'b1;
            if (fire && overrun) missed <= 1'b1;
        end
    end

    // Read mux over current register values (pre-write on a same-cycle write).
    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CONTROL: rd_mux = {{(32-CTRL_W){1'b0}}, ctrl};
            REG_STATUS:  rd_mux = {30'd0, missed, pend};
            REG_CMP_LO:  rd_mux = compare[31:0];
            REG_CMP_HI:  rd_mux = compare[63:32];
            REG_PER_LO:  rd_mux = period[31:0];
            REG_PER_HI:  rd_mux = period[63:32];
            REG_SNAP_LO: rd_mux = timestamp[31:0];
            REG_SNAP_HI: rd_mux = snap_hi;
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data; a SNAP_LO read also captures the matching high word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avalon_slave_readdata <= '0;
            snap_hi               <= '0;
        end else if (avalon_slave_read) begin
            avalon_slave_readdata <= rd_mux;
            if (addr == REG_SNAP_LO) snap_hi <= timestamp[63:32];
        end
    end

    // Level interrupt, one cycle behind PEND / IRQ_EN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= pend && ctrl[CTRL_IRQ_EN];
        end
    end

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: read expectations are queued when the
// read is issued and compared when readdata becomes valid.
module tb_timer_alarm;
    import timer_alarm_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [63:0] ts;
    logic [2:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    timer_alarm #(.ADDR_W(3), .TS_W(64)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .timestamp              (ts),
        .avalon_slave_address   (address),
        .avalon_slave_read      (read),
        .avalon_slave_readdata  (readdata),
        .avalon_slave_write     (write),
        .avalon_slave_writedata (writedata),
        .irq                    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: readdata is valid #1 after the edge that sampled read
    initial begin
        logic rd_seen;
        forever begin
            @(posedge clk);
            rd_seen = read;
            #1;
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_read", 1, 0);
                end else begin
                    check_eq(tag_q.pop_front(), {32'd0, readdata}, {32'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // All bus tasks start at a negedge and return at the following negedge
    task automatic rd(input reg_addr_e a, input logic [31:0] exp, input string tag);
        address = a;
        read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wr(input reg_addr_e a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rdwr(input reg_addr_e a, input logic [31:0] d, input logic [31:0] exp, input string tag);
        address   = a;
        writedata = d;
        write     = 1'b1;
        read      = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic ramp_to(input logic [63:0] tgt);
        while (ts < tgt) begin
            ts = ts + 64'd1;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        ts        = '0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        idle(3);
        reset_n = 1'b1;

        // Reset state of every register
        for (int unsigned i = 0; i < 8; i++) begin
            rd(reg_addr_e'(i[2:0]), 32'd0, $sformatf("reset_reg%0d", i));
        end
        check_eq("reset_irq", {63'd0, irq}, 64'd0);

        // One-shot at 100
        wr(REG_CMP_LO, 32'd100);
        wr(REG_CMP_HI, 32'd0);
        wr(REG_CONTROL, 32'b101);
        ramp_to(99);
        check_eq("os_irq_before", {63'd0, irq}, 64'd0);
        ts = 64'd100;
        idle(1);
        check_eq("os_irq_lag", {63'd0, irq}, 64'd0);
        rd(REG_STATUS, 32'd1, "os_pend");
        check_eq("os_irq_set", {63'd0, irq}, 64'd1);
        rd(REG_CONTROL, 32'b100, "os_en_cleared");
        wr(REG_STATUS, 32'd1);
        check_eq("os_irq_hold", {63'd0, irq}, 64'd1);
        idle(1);
        check_eq("os_irq_drop", {63'd0, irq}, 64'd0);
        ramp_to(102);
        rd(REG_STATUS, 32'd0, "os_no_refire");

        // Reset while PEND and irq are asserted
        wr(REG_CONTROL, 32'b101);
        idle(2);
        check_eq("rst_irq_before", {63'd0, irq}, 64'd1);
        do_reset();
        check_eq("rst_irq_after", {63'd0, irq}, 64'd0);
        rd(REG_STATUS, 32'd0, "rst_pend");
        rd(REG_CMP_LO, 32'd0, "rst_compare");

        // Periodic: 50, 70, 90
        ts = '0;
        wr(REG_CMP_LO, 32'd50);
        wr(REG_CMP_HI, 32'd0);
        wr(REG_PER_LO, 32'd20);
        wr(REG_PER_HI, 32'd0);
        wr(REG_CONTROL, 32'b111);
        ramp_to(49);
        rd(REG_STATUS, 32'd0, "per_early");
        ramp_to(50);
        rd(REG_STATUS, 32'd1, "per_hit50");
        rd(REG_CMP_LO, 32'd70, "per_cmp70");
        wr(REG_STATUS, 32'd1);
        ramp_to(69);
        rd(REG_STATUS, 32'd0, "per_gap1");
        ramp_to(70);
        rd(REG_STATUS, 32'd1, "per_hit70");
        wr(REG_STATUS, 32'd1);
        ramp_to(89);
        rd(REG_STATUS, 32'd0, "per_gap2");
        ramp_to(90);
        rd(REG_STATUS, 32'd1, "per_hit90");
        rd(REG_CMP_LO, 32'd110, "per_cmp110");
        rd(REG_CMP_HI, 32'd0, "per_cmp110_hi");

        // Overrun: compare 10, period 5, jump 9 -> 40
        do_reset();
        ts = '0;
        wr(REG_CMP_LO, 32'd10);
        wr(REG_CMP_HI, 32'd0);
        wr(REG_PER_LO, 32'd5);
        wr(REG_PER_HI, 32'd0);
        wr(REG_CONTROL, 32'b011);
        ramp_to(9);
        rd(REG_STATUS, 32'd0, "ovr_before");
        ts = 64'd40;
        idle(1);
        rd(REG_STATUS, 32'd3, "ovr_missed");
        rd(REG_CMP_LO, 32'd45, "ovr_cmp45");
        check_eq("ovr_irq_masked", {63'd0, irq}, 64'd0);

        // Periodic with zero period behaves as one-shot
        wr(REG_CONTROL, 32'd0);
        wr(REG_PER_LO, 32'd0);
        wr(REG_PER_HI, 32'd0);
        wr(REG_CMP_LO, 32'd50);
        wr(REG_CMP_HI, 32'd0);
        wr(REG_STATUS, 32'd3);
        wr(REG_CONTROL, 32'b011);
        ramp_to(50);
        idle(1);
        rd(REG_CONTROL, 32'b010, "p0_en_cleared");
        rd(REG_STATUS, 32'd1, "p0_pend");
        rd(REG_CMP_LO, 32'd50, "p0_cmp_kept");

        // Atomic compare commit
        do_reset();
        ts = '0;
        wr(REG_CMP_LO, 32'd0);
        wr(REG_CMP_HI, 32'd1);
        wr(REG_CMP_LO, 32'hFFFF_FFFF);
        rd(REG_CMP_LO, 32'd0, "atm_lo_old");
        rd(REG_CMP_HI, 32'd1, "atm_hi_old");
        wr(REG_CONTROL, 32'b001);
        ts = 64'h0000_0000_FFFF_FFFF;
        idle(2);
        rd(REG_STATUS, 32'd0, "atm_no_hit");
        wr(REG_CMP_HI, 32'd0);
        rd(REG_CMP_LO, 32'hFFFF_FFFF, "atm_lo_new");
        rd(REG_STATUS, 32'd1, "atm_hit");

        // Same-cycle read and write return the pre-write value
        rdwr(REG_CONTROL, 32'b110, 32'd0, "rw_prewrite");
        rd(REG_CONTROL, 32'b110, "rw_postwrite");

        // Tear-free snapshot
        ts = 64'h0000_0001_FFFF_FFFF;
        rd(REG_SNAP_LO, 32'hFFFF_FFFF, "snap_lo");
        ts = 64'h0000_0002_0000_0003;
        rd(REG_SNAP_HI, 32'h0000_0001, "snap_hi");
        wr(REG_SNAP_HI, 32'h1234_5678);
        rd(REG_SNAP_HI, 32'h0000_0001, "snap_hi_ro");

        idle(2);
        check_eq("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
